// File: rtl/read_burst_issuer.sv
// read_burst_issuer
//   Splits a test command (start address, word count) into Avalon-MM read
//   bursts of at most MAX_BURST words. Each accepted burst is also described
//   to the compare stage (address, length-1, pattern, mode). Issue is
//   throttled by two credits: words requested but not yet returned
//   (MAX_OUT_WORDS) and bursts issued but not fully returned (MAX_OUT_BURSTS).
//   A compare error sets a sticky abort flag that drains the engine and
//   blocks further reads until test_start_i.
//
// Ports
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   test_start_i             pulse: clear abort flag and credit counters
//   cmd_*                    test command handshake and fields
//   amm_*                    Avalon-MM read master (readdata not used here)
//   cmp_*                    burst descriptor write to compare stage, error strobe
//   busy_o                   command in progress or reads outstanding
//
// Configuration
//   READ_ISSUER_RND_PTRN_EN  when defined, LFSR pattern mode and the ADV state
//                            are compiled in; otherwise cmd_rnd_i is ignored
//                            and every burst carries the command's pattern.

module read_burst_issuer #(
    parameter int ADDR_W         = 32,
    parameter int MAX_BURST      = 64,
    parameter int MAX_OUT_WORDS  = 64,
    parameter int MAX_OUT_BURSTS = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              test_start_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_words_i,
    input  logic [7:0]        cmd_ptrn_i,
    input  logic              cmd_rnd_i,
    output logic [ADDR_W-1:0] amm_address_o,
    output logic              amm_read_o,
    output logic [6:0]        amm_burstcount_o,
    input  logic              amm_waitrequest_i,
    input  logic              amm_readdatavalid_i,
    output logic              cmp_en_o,
    output logic [ADDR_W-1:0] cmp_addr_o,
    output logic [5:0]        cmp_words_o,
    output logic [7:0]        cmp_ptrn_o,
    output logic              cmp_rnd_o,
    input  logic              cmp_error_i,
    output logic              busy_o
);

    localparam int OW_W  = $clog2(MAX_OUT_WORDS + 1);
    localparam int OB_W  = $clog2(MAX_OUT_BURSTS + 1);
    localparam int PTR_W = (MAX_OUT_BURSTS > 1) ? $clog2(MAX_OUT_BURSTS) : 1;

`ifdef READ_ISSUER_RND_PTRN_EN
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_DRAIN, S_ADV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_DRAIN} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [32:0]       left_q, left_d;          // words still to request (count, not count-1)
    logic [6:0]        len_q, len_d;            // length of the burst being requested
    logic [7:0]        ptrn_q, ptrn_d;
    logic              abort_q, abort_d;
    logic              start_pend_q, start_pend_d; // test_start seen while a request is held
    logic [OW_W-1:0]   out_words_q, out_words_d;
    logic [OB_W-1:0]   out_bursts_q, out_bursts_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]        ret_cnt_q, ret_cnt_d;    // words returned so far for the oldest burst
`ifdef READ_ISSUER_RND_PTRN_EN
    logic              rnd_q, rnd_d;
    logic [6:0]        adv_cnt_q, adv_cnt_d;
`else
    logic              unused_rnd;
    assign unused_rnd = cmd_rnd_i;
`endif

    // Lengths of outstanding bursts, oldest at rd_ptr_q.
    logic [6:0] len_mem [MAX_OUT_BURSTS];

    logic [6:0] calc_len;
    logic       credit_ok, accept, squash, abort_now, push, ret_ok, ret_last;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT_BURSTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        calc_len  = (left_q >= 33'(MAX_BURST)) ? 7'(MAX_BURST) : 7'(left_q);
        credit_ok = (32'(out_words_q) + 32'(calc_len) <= 32'(MAX_OUT_WORDS)) &&
                    (32'(out_bursts_q) < 32'(MAX_OUT_BURSTS));
        accept    = (state_q == S_REQ) && !amm_waitrequest_i;
        squash    = start_pend_q || test_start_i;
        abort_now = abort_q || cmp_error_i;
        // A request completed after test_start is not tracked: credits were just cleared.
        push      = accept && !squash;
        ret_ok    = amm_readdatavalid_i && (out_words_q != '0);
        ret_last  = ret_ok && (out_bursts_q != '0) && (ret_cnt_q + 7'd1 == len_mem[rd_ptr_q]);
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (test_start_i && state_q != S_REQ) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cmd_valid_i && !abort_q) state_d = S_CALC;
                S_CALC:  if (abort_now) state_d = S_DRAIN;
                         else if (credit_ok) state_d = S_REQ;
                S_REQ: begin
                    if (accept) begin
                        if (squash)                          state_d = S_IDLE;
                        else if (abort_now)                  state_d = S_DRAIN;
`ifdef READ_ISSUER_RND_PTRN_EN
                        else if (rnd_q)                      state_d = S_ADV;
`endif
                        else if (left_q != 33'(len_q))       state_d = S_CALC;
                        else                                 state_d = S_DRAIN;
                    end
                end
`ifdef READ_ISSUER_RND_PTRN_EN
                S_ADV: begin
                    if (abort_now)              state_d = S_DRAIN;
                    else if (adv_cnt_q == 7'd0) state_d = (left_q != 33'd0) ? S_CALC : S_DRAIN;
                end
`endif
                S_DRAIN: if (out_words_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        cmd_ready_o      = (state_q == S_IDLE);
        amm_read_o       = (state_q == S_REQ);
        amm_address_o    = addr_q;
        amm_burstcount_o = len_q;
        cmp_en_o         = push;
        cmp_addr_o       = addr_q;
        cmp_words_o      = 6'(len_q - 7'd1);
        cmp_ptrn_o       = ptrn_q;
`ifdef READ_ISSUER_RND_PTRN_EN
        cmp_rnd_o        = rnd_q;
`else
        cmp_rnd_o        = 1'b0;
`endif
        busy_o           = !((state_q == S_IDLE) && (out_words_q == '0));
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        addr_d       = addr_q;
        left_d       = left_q;
        len_d        = len_q;
        ptrn_d       = ptrn_q;
        abort_d      = abort_q || cmp_error_i;
        start_pend_d = start_pend_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ret_cnt_d    = ret_cnt_q;
`ifdef READ_ISSUER_RND_PTRN_EN
        rnd_d        = rnd_q;
        adv_cnt_d    = adv_cnt_q;
`endif

        if (state_q == S_IDLE && cmd_valid_i) begin
            addr_d = cmd_addr_i;
            left_d = {1'b0, cmd_words_i} + 33'd1;
            ptrn_d = cmd_ptrn_i;
`ifdef READ_ISSUER_RND_PTRN_EN
            rnd_d  = cmd_rnd_i;
`endif
        end

        if (state_q == S_CALC) len_d = calc_len;

        if (push) begin
            addr_d   = addr_q + ADDR_W'(len_q);   // wraps modulo 2^ADDR_W
            left_d   = left_q - 33'(len_q);
            wr_ptr_d = ptr_next(wr_ptr_q);
`ifdef READ_ISSUER_RND_PTRN_EN
            adv_cnt_d = len_q - 7'd1;
`endif
        end

`ifdef READ_ISSUER_RND_PTRN_EN
        if (state_q == S_ADV) begin
            ptrn_d    = {ptrn_q[6:0], ptrn_q[7] ^ ptrn_q[5] ^ ptrn_q[4] ^ ptrn_q[3]};
            adv_cnt_d = adv_cnt_q - 7'd1;
        end
`endif

        if (ret_last) begin
            rd_ptr_d  = ptr_next(rd_ptr_q);
            ret_cnt_d = 7'd0;
        end else if (ret_ok) begin
            ret_cnt_d = ret_cnt_q + 7'd1;
        end

        // Net update so a same-cycle issue and return never loses a count.
        out_words_d  = out_words_q + (push ? OW_W'(len_q) : '0) - (ret_ok ? OW_W'(1) : '0);
        out_bursts_d = out_bursts_q + (push ? OB_W'(1) : '0) - (ret_last ? OB_W'(1) : '0);

        if (state_q == S_REQ && test_start_i && !accept) start_pend_d = 1'b1;
        if (accept)                                      start_pend_d = 1'b0;

        if (test_start_i) begin
            abort_d      = 1'b0;
            out_words_d  = '0;
            out_bursts_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ret_cnt_d    = 7'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_q       <= '0;
            left_q       <= '0;
            len_q        <= '0;
            ptrn_q       <= '0;
            abort_q      <= 1'b0;
            start_pend_q <= 1'b0;
            out_words_q  <= '0;
            out_bursts_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ret_cnt_q    <= '0;
`ifdef READ_ISSUER_RND_PTRN_EN
            rnd_q        <= 1'b0;
            adv_cnt_q    <= '0;
`endif
        end else begin
            addr_q       <= addr_d;
            left_q       <= left_d;
            len_q        <= len_d;
            ptrn_q       <= ptrn_d;
            abort_q      <= abort_d;
            start_pend_q <= start_pend_d;
            out_words_q  <= out_words_d;
            out_bursts_q <= out_bursts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ret_cnt_q    <= ret_cnt_d;
`ifdef READ_ISSUER_RND_PTRN_EN
            rnd_q        <= rnd_d;
            adv_cnt_q    <= adv_cnt_d;
`endif
        end
    end

    // NOTE: the length store is not reset; entries are only read after being written, and the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push) len_mem[wr_ptr_q] <= len_q;
    end

endmodule

// File: tb/tb_read_burst_issuer.sv
// Self-checking bench for read_burst_issuer: directed scenarios plus
// randomized commands against a burst-list model computed from the
// command's address and word count.

module tb_read_burst_issuer;

    localparam int ADDR_W         = 32;
    localparam int MAX_BURST      = 64;
    localparam int MAX_OUT_WORDS  = 64;
    localparam int MAX_OUT_BURSTS = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              test_start_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [31:0]       cmd_words_i;
    logic [7:0]        cmd_ptrn_i;
    logic              cmd_rnd_i;
    logic [ADDR_W-1:0] amm_address_o;
    logic              amm_read_o;
    logic [6:0]        amm_burstcount_o;
    logic              amm_waitrequest_i;
    logic              amm_readdatavalid_i;
    logic              cmp_en_o;
    logic [ADDR_W-1:0] cmp_addr_o;
    logic [5:0]        cmp_words_o;
    logic [7:0]        cmp_ptrn_o;
    logic              cmp_rnd_o;
    logic              cmp_error_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    read_burst_issuer #(
        .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
        .MAX_OUT_WORDS(MAX_OUT_WORDS), .MAX_OUT_BURSTS(MAX_OUT_BURSTS)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .test_start_i(test_start_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_words_i(cmd_words_i),
        .cmd_ptrn_i(cmd_ptrn_i), .cmd_rnd_i(cmd_rnd_i),
        .amm_address_o(amm_address_o), .amm_read_o(amm_read_o),
        .amm_burstcount_o(amm_burstcount_o), .amm_waitrequest_i(amm_waitrequest_i),
        .amm_readdatavalid_i(amm_readdatavalid_i),
        .cmp_en_o(cmp_en_o), .cmp_addr_o(cmp_addr_o), .cmp_words_o(cmp_words_o),
        .cmp_ptrn_o(cmp_ptrn_o), .cmp_rnd_o(cmp_rnd_o),
        .cmp_error_i(cmp_error_i), .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [7:0]  ptrn;
        logic        rnd;
    } burst_t;

    burst_t exp_q[$];   // model
    burst_t acc_q[$];   // accepted Avalon reads
    burst_t cmp_q[$];   // compare-stage descriptors

    int checks   = 0;
    int failures = 0;

    // Slave controls (written by the main sequence, read by the slave process)
    bit wr_force = 1'b0;
    bit wr_rand  = 1'b0;
    bit rdv_rand = 1'b0;
    int rdv_budget = -1;   // -1 = unlimited
    int pend_words = 0;

    // Outstanding tracking seen on the bus
    int out_w = 0;
    int head_ret = 0;
    int out_lens[$];
    int max_out_w = 0;
    int max_out_b = 0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    // Avalon slave: inputs change 1 time unit after the rising edge.
    initial begin
        amm_waitrequest_i   = 1'b0;
        amm_readdatavalid_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            amm_waitrequest_i = wr_force || (wr_rand && ($urandom_range(0, 2) == 0));
            if (pend_words > 0 && rdv_budget != 0 && (!rdv_rand || $urandom_range(0, 1) == 1)) begin
                amm_readdatavalid_i = 1'b1;
                pend_words--;
                if (rdv_budget > 0) rdv_budget--;
            end else begin
                amm_readdatavalid_i = 1'b0;
            end
        end
    end

    // Bus monitor on the falling edge.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (amm_read_o && !amm_waitrequest_i) begin
                acc_q.push_back('{addr: amm_address_o, len: int'(amm_burstcount_o), ptrn: 8'h00, rnd: 1'b0});
                pend_words += int'(amm_burstcount_o);
                out_w      += int'(amm_burstcount_o);
                out_lens.push_back(int'(amm_burstcount_o));
            end
            if (cmp_en_o)
                cmp_q.push_back('{addr: cmp_addr_o, len: int'(cmp_words_o) + 1, ptrn: cmp_ptrn_o, rnd: cmp_rnd_o});
            if (amm_readdatavalid_i) begin
                out_w--;
                head_ret++;
                if (out_lens.size() > 0 && head_ret == out_lens[0]) begin
                    void'(out_lens.pop_front());
                    head_ret = 0;
                end
            end
            if (out_w > max_out_w) max_out_w = out_w;
            if (out_lens.size() > max_out_b) max_out_b = out_lens.size();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i); #2;
    endtask

    task automatic clear_tb();
        exp_q.delete(); acc_q.delete(); cmp_q.delete(); out_lens.delete();
        out_w = 0; head_ret = 0; max_out_w = 0; max_out_b = 0;
    endtask

    // Expected bursts from the command alone: chunks of MAX_BURST, address wrapping.
    task automatic model(input logic [31:0] a, input logic [31:0] w, input logic [7:0] p, input logic r);
        longint     rem = longint'(w) + 1;
        logic [31:0] ad = a;
        logic [7:0]  pat = p;
        logic        r_eff;
`ifdef READ_ISSUER_RND_PTRN_EN
        r_eff = r;
`else
        r_eff = 1'b0;
`endif
        while (rem > 0) begin
            int len;
            len = (rem > MAX_BURST) ? MAX_BURST : int'(rem);
            exp_q.push_back('{addr: ad, len: len, ptrn: pat, rnd: r_eff});
            if (r_eff) for (int k = 0; k < len; k++) pat = lfsr_step(pat);
            ad  = ad + 32'(len);
            rem = rem - len;
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] w, input logic [7:0] p, input logic r);
        int n = 0;
        while (!cmd_ready_o && n < 500) begin cyc(); n++; end
        check("cmd_ready_before_cmd", longint'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_words_i = w; cmd_ptrn_i = p; cmd_rnd_i = r;
        cyc();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_read(input string tag);
        int n = 0;
        while (!amm_read_o && n < 200) begin cyc(); n++; end
        check({tag, "_read_seen"}, longint'(amm_read_o), 1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (busy_o && n < limit) begin cyc(); n++; end
        check({tag, "_done_in_time"}, longint'(busy_o), 0);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_n_reads"}, acc_q.size(), exp_q.size());
        check({tag, "_n_cmp"},   cmp_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < acc_q.size()) begin
                check($sformatf("%s_rd%0d_addr", tag, i), acc_q[i].addr, exp_q[i].addr);
                check($sformatf("%s_rd%0d_len", tag, i),  acc_q[i].len,  exp_q[i].len);
            end
            if (i < cmp_q.size()) begin
                check($sformatf("%s_cmp%0d_addr", tag, i), cmp_q[i].addr, exp_q[i].addr);
                check($sformatf("%s_cmp%0d_len", tag, i),  cmp_q[i].len,  exp_q[i].len);
                check($sformatf("%s_cmp%0d_ptrn", tag, i), cmp_q[i].ptrn, exp_q[i].ptrn);
                check($sformatf("%s_cmp%0d_rnd", tag, i),  cmp_q[i].rnd,  exp_q[i].rnd);
            end
        end
        check({tag, "_max_out_words_ok"}, longint'(max_out_w <= MAX_OUT_WORDS), 1);
        check({tag, "_max_out_bursts_ok"}, longint'(max_out_b <= MAX_OUT_BURSTS), 1);
        clear_tb();
    endtask

    initial begin
        logic [31:0] a, ha;
        logic [6:0]  hb;
        logic [7:0]  p;

        rst_n_i = 1'b0; test_start_i = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0;
        cmd_words_i = '0; cmd_ptrn_i = '0; cmd_rnd_i = 1'b0; cmp_error_i = 1'b0;
        repeat (3) cyc();

        // Reset state
        check("rst_cmd_ready", longint'(cmd_ready_o), 1);
        check("rst_busy",      longint'(busy_o), 0);
        check("rst_amm_read",  longint'(amm_read_o), 0);
        check("rst_cmp_en",    longint'(cmp_en_o), 0);
        rst_n_i = 1'b1;
        cyc();

        // 150 words at 0x100, no waitrequest: 64/64/22
        send_cmd(32'h100, 32'd149, 8'hA5, 1'b0);
        model(32'h100, 32'd149, 8'hA5, 1'b0);
        wait_done("seq150", 2000);
        compare_all("seq150");

        // Credit stall: reads withheld
        rdv_budget = 0;
        send_cmd(32'h2000, 32'd299, 8'h3C, 1'b0);
        model(32'h2000, 32'd299, 8'h3C, 1'b0);
        repeat (40) cyc();
        check("stall_one_burst", acc_q.size(), 1);
        check("stall_busy", longint'(busy_o), 1);
        rdv_budget = 1;
        repeat (40) cyc();
        check("stall_after_1_ret", acc_q.size(), 1);
        rdv_budget = 62;
        repeat (100) cyc();
        check("stall_after_63_ret", acc_q.size(), 1);
        rdv_budget = 1;
        repeat (20) cyc();
        check("resume_after_64_ret", acc_q.size(), 2);
        rdv_budget = -1;
        wait_done("stall", 3000);
        compare_all("stall");

        // Waitrequest held 5 cycles
        wr_force = 1'b1;
        a = $urandom;
        send_cmd(a, 32'd9, 8'h5A, 1'b0);
        model(a, 32'd9, 8'h5A, 1'b0);
        wait_read("wreq");
        ha = amm_address_o;
        hb = amm_burstcount_o;
        check("wreq_addr", ha, a);
        check("wreq_bc", hb, 10);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) cyc();
            check($sformatf("wreq_c%0d_read", k), longint'(amm_read_o), 1);
            check($sformatf("wreq_c%0d_addr", k), amm_address_o, ha);
            check($sformatf("wreq_c%0d_bc", k), amm_burstcount_o, hb);
            check($sformatf("wreq_c%0d_cmp_en", k), longint'(cmp_en_o), 0);
            if (k == 5) wr_force = 1'b0;
        end
        cyc();
        check("wreq_c6_cmp_en", longint'(cmp_en_o), 1);
        check("wreq_c6_addr", amm_address_o, ha);
        cyc();
        check("wreq_c7_cmp_en", longint'(cmp_en_o), 0);
        wait_done("wreq", 500);
        compare_all("wreq");

        // Compare error while a request is held
        wr_force = 1'b1;
        send_cmd(32'h4000, 32'd199, 8'h11, 1'b0);
        wait_read("err");
        cyc();
        cmp_error_i = 1'b1;
        cyc();
        cmp_error_i = 1'b0;
        check("err_req_held", longint'(amm_read_o), 1);
        check("err_no_cmp_yet", longint'(cmp_en_o), 0);
        wr_force = 1'b0;
        cyc();
        check("err_cmp_en", longint'(cmp_en_o), 1);
        wait_done("err", 500);
        repeat (20) cyc();
        check("err_n_reads", acc_q.size(), 1);
        check("err_n_cmp", cmp_q.size(), 1);
        check("err_rd_addr", acc_q.size() > 0 ? acc_q[0].addr : 32'hDEAD, 32'h4000);
        check("err_idle_busy", longint'(busy_o), 0);
        clear_tb();

        // Sticky abort: command accepted, no reads
        send_cmd(32'h5000, 32'd20, 8'h22, 1'b0);
        repeat (20) cyc();
        check("abort_no_reads", acc_q.size(), 0);
        check("abort_ready", longint'(cmd_ready_o), 1);
        check("abort_busy", longint'(busy_o), 0);
        test_start_i = 1'b1;
        cyc();
        test_start_i = 1'b0;
        cyc();

        // Single-word command after test_start
        send_cmd(32'h6000, 32'd0, 8'h33, 1'b0);
        model(32'h6000, 32'd0, 8'h33, 1'b0);
        wait_done("one", 500);
        compare_all("one");

`ifdef READ_ISSUER_RND_PTRN_EN
        // LFSR mode: second descriptor carries the pattern stepped 64 times
        send_cmd(32'h7000, 32'd127, 8'h01, 1'b1);
        wait_done("lfsr", 2000);
        p = 8'h01;
        for (int k = 0; k < 64; k++) p = lfsr_step(p);
        check("lfsr_n_cmp", cmp_q.size(), 2);
        check("lfsr_cmp1_ptrn", cmp_q.size() > 1 ? cmp_q[1].ptrn : 8'h00, p);
        clear_tb();
`endif

        // Reset mid-request dominates test_start and error
        wr_force = 1'b1;
        send_cmd(32'h8000, 32'd200, 8'h44, 1'b0);
        wait_read("rst");
        cyc();
        rst_n_i = 1'b0; test_start_i = 1'b1; cmp_error_i = 1'b1; pend_words = 0;
        cyc();
        check("mid_rst_cmd_ready", longint'(cmd_ready_o), 1);
        check("mid_rst_read", longint'(amm_read_o), 0);
        check("mid_rst_cmp_en", longint'(cmp_en_o), 0);
        check("mid_rst_busy", longint'(busy_o), 0);
        rst_n_i = 1'b1; test_start_i = 1'b0; cmp_error_i = 1'b0; wr_force = 1'b0;
        pend_words = 0;
        clear_tb();
        cyc();

        // Address wrap
        send_cmd(32'hFFFF_FFC0, 32'd127, 8'h55, 1'b0);
        model(32'hFFFF_FFC0, 32'd127, 8'h55, 1'b0);
        wait_done("wrap", 2000);
        compare_all("wrap");

        // Randomized commands with random waitrequest and return gaps
        wr_rand = 1'b1;
        rdv_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [31:0] ra, rw;
            logic [7:0]  rp;
            logic        rr;
            ra = (t % 2 == 0) ? $urandom : (32'hFFFF_FF00 + 32'($urandom_range(0, 255)));
            rw = 32'($urandom_range(0, 400));
            rp = 8'($urandom);
            rr = 1'($urandom_range(0, 1));
            send_cmd(ra, rw, rp, rr);
            model(ra, rw, rp, rr);
            wait_done($sformatf("rnd%0d", t), 8000);
            compare_all($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
